// File: rtl/apb_req_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Drives the SETUP/ACCESS phases itself and aborts transfers stalled past TIMEOUT.
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic [IDX_W-1:0]      last, last_nxt;
  logic [IDX_W-1:0]      owner, owner_nxt;
  logic [NUM_REQ-1:0]    gnt_nxt, done_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
  logic                  rsp_err_nxt, busy_nxt, psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A requester in its own done cycle is masked so dropping req late cannot re-grant it.
  logic [NUM_REQ-1:0] elig;
  logic               win_found;
  logic [IDX_W-1:0]   win, cand;

  always_comb begin
    elig      = req & ~done;
    win_found = 1'b0;
    win       = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    last_nxt      = last;
    owner_nxt     = owner;
    gnt_nxt       = gnt;
    done_nxt      = '0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    busy_nxt      = busy;
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    case (state)
      IDLE: begin
        if (win_found) begin
          owner_nxt      = win;
          paddr_nxt      = addr_arr[win];
          pwdata_nxt     = wdata_arr[win];
          pwrite_nxt     = req_write[win];
          gnt_nxt        = '0;
          gnt_nxt[win]   = 1'b1;
          psel_nxt       = 1'b1;
          penable_nxt    = 1'b0;
          busy_nxt       = 1'b1;
          state_nxt      = SETUP;
        end else begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          busy_nxt    = 1'b0;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (pready || cnt == 8'(TIMEOUT - 1)) begin
          // Normal completion takes priority over an abort on the same cycle.
          rsp_rdata_nxt   = pready ? prdata : '0;
          rsp_err_nxt     = pready ? pslverr : 1'b1;
          done_nxt[owner] = 1'b1;
          last_nxt        = owner;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          busy_nxt        = 1'b0;
          gnt_nxt         = '0;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        busy_nxt    = 1'b0;
        gnt_nxt     = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
      owner     <= '0;
      gnt       <= '0;
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      owner     <= owner_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      busy      <= busy_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
`timescale 1ns/1ps
// Bench for apb_req_arbiter: table of single transfers, directed multi-cycle
// sequences, and a randomized run against a transaction-level reference model.
module tb_apb_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, busy, psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata, prdata;
  logic            pready, pslverr;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    int            idx;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;      // ACCESS samples with pready=0 before pready=1; 255 = never
    logic [DW-1:0] rdata_in;
    bit            slverr_in;
    int            exp_lat;    // clock edges from the sampling edge (counted as 1) to done
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
  } vec_t;

  vec_t vecs[5];

  // Reference model state
  bit            m_active;
  int            m_age, m_owner, m_last;
  logic [N-1:0]  exp_gnt, exp_done;
  logic [DW-1:0] exp_rdata, exp_pwdata;
  logic [AW-1:0] exp_paddr;
  logic          exp_err, exp_busy, exp_psel, exp_pen, exp_pwrite;

  task automatic clear_inputs();
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = 99;
    if ($countones(v) == 1)
      for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    int cyc = 0;
    int k = 0;
    bit fin = 1'b0;
    logic [N-1:0] oh;
    oh = '0;
    oh[v.idx] = 1'b1;
    req = oh;
    req_write[v.idx] = v.wr;
    req_addr[v.idx*AW +: AW] = v.addr;
    req_wdata[v.idx*DW +: DW] = v.wdata;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'hFFFF_FFFF;
    while (!fin && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      req_write[v.idx] = ~v.wr;
      req_addr[v.idx*AW +: AW] = ~v.addr;
      req_wdata[v.idx*DW +: DW] = ~v.wdata;
      if (done != '0) fin = 1'b1;
      else begin
        if (cyc == 1)
          check($sformatf("v%0d_setup", n), {psel, penable, busy, gnt, pwrite, paddr, pwdata},
                {1'b1, 1'b0, 1'b1, oh, v.wr, v.addr, v.wdata});
        else
          check($sformatf("v%0d_hold", n), {psel, penable, busy, gnt, pwrite, paddr, pwdata},
                {1'b1, 1'b1, 1'b1, oh, v.wr, v.addr, v.wdata});
        if (cyc >= 2) begin
          pready  = (k >= v.waits);
          pslverr = pready ? v.slverr_in : 1'b0;
          prdata  = pready ? v.rdata_in : 32'hFFFF_FFFF;
          k++;
        end
      end
    end
    check($sformatf("v%0d_latency", n), cyc, v.exp_lat);
    check($sformatf("v%0d_done", n), done, oh);
    check($sformatf("v%0d_rsp", n), {rsp_err, rsp_rdata}, {v.exp_err, v.exp_rdata});
    check($sformatf("v%0d_idle", n), {psel, penable, busy, gnt}, '0);
    req = '0; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
  endtask

  task automatic seq_fairness();
    int got[$];
    int zero_run = 0;
    bit prev_psel = 1'b0;
    logic [N-1:0] dropped = '0;
    do_reset();
    req = '1; pready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      req = (req | dropped) & ~done;
      dropped = done;
      if (psel && !prev_psel) begin
        if (got.size() > 0) check("rr_gap", zero_run, 1);
        got.push_back(oh_idx(gnt));
        zero_run = 0;
      end else if (!psel) zero_run++;
      prev_psel = psel;
    end
    check("rr_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) check($sformatf("rr_order%0d", i), got[i], i % N);
  endtask

  task automatic seq_timeout();
    int cyc = 0;
    do_reset();
    req = 4'b0110; pready = 1'b0; prdata = 32'hFFFF_FFFF; pslverr = 1'b0;
    while (done == '0 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("to_latency", cyc, TO + 2);
    check("to_rsp", {done, psel, rsp_err, rsp_rdata}, {4'b0010, 1'b0, 1'b1, 32'h0});
    req[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("to_next_grant", {psel, penable, gnt}, {1'b1, 1'b0, 4'b0100});
  endtask

  task automatic seq_reset_mid();
    do_reset();
    req = 4'b0010; pready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_pre", {psel, penable, gnt}, {1'b1, 1'b1, 4'b0010});
    resetn = 1'b0;
    #1;
    check("rst_async", {psel, penable, gnt, done, busy}, '0);
    req = 4'b1001;
    @(negedge clk);
    check("rst_no_done", {done, psel}, '0);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_first_grant", {psel, gnt}, {1'b1, 4'b0001});
  endtask

  task automatic seq_mask();
    int cyc = 0;
    do_reset();
    req = 4'b0010; pready = 1'b1; prdata = 32'h0000_0042;
    while (done == '0 && cyc < 10) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("mask_done", {done, rsp_rdata}, {4'b0010, 32'h0000_0042});
    @(posedge clk);
    @(negedge clk);
    check("mask_no_grant", {psel, gnt, done}, '0);
    @(posedge clk);
    @(negedge clk);
    check("mask_regrant", {psel, gnt}, {1'b1, 4'b0010});
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_age = 0; m_owner = 0; m_last = N - 1;
    exp_gnt = '0; exp_done = '0; exp_rdata = '0; exp_pwdata = '0; exp_paddr = '0;
    exp_err = 1'b0; exp_busy = 1'b0; exp_psel = 1'b0; exp_pen = 1'b0; exp_pwrite = 1'b0;
  endtask

  // Predicts the outputs after the next rising edge from the current inputs.
  task automatic model_step();
    logic [N-1:0] mask;
    int pick;
    mask = exp_done;
    exp_done = '0;
    if (!m_active) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (pick < 0 && req[i] && !mask[i]) pick = i;
      end
      if (pick >= 0) begin
        m_active = 1'b1; m_age = 0; m_owner = pick;
        exp_psel = 1'b1; exp_pen = 1'b0; exp_busy = 1'b1;
        exp_gnt = '0; exp_gnt[pick] = 1'b1;
        exp_paddr  = req_addr[pick*AW +: AW];
        exp_pwdata = req_wdata[pick*DW +: DW];
        exp_pwrite = req_write[pick];
      end
    end else if (m_age == 0) begin
      exp_pen = 1'b1;
      m_age = 1;
    end else if (pready || m_age == TO) begin
      exp_rdata = pready ? prdata : '0;
      exp_err   = pready ? pslverr : 1'b1;
      exp_done[m_owner] = 1'b1;
      m_last = m_owner; m_active = 1'b0;
      exp_psel = 1'b0; exp_pen = 1'b0; exp_busy = 1'b0; exp_gnt = '0;
    end else begin
      m_age++;
    end
  endtask

  task automatic seq_random(input int cycles);
    bit stuck = 1'b0;
    do_reset();
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      check("rnd_ctrl", {gnt, done, busy, psel, penable, pwrite, rsp_err},
            {exp_gnt, exp_done, exp_busy, exp_psel, exp_pen, exp_pwrite, exp_err});
      check("rnd_data", {paddr, pwdata, rsp_rdata}, {exp_paddr, exp_pwdata, exp_rdata});
      for (int i = 0; i < N; i++) begin
        if (exp_done[i]) begin
          if ($urandom_range(0, 2) != 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        req_write[i] = ($urandom_range(0, 1) == 1);
        req_addr[i*AW +: AW] = AW'($urandom);
        req_wdata[i*DW +: DW] = $urandom;
      end
      if (!stuck && $urandom_range(0, 63) == 0) stuck = 1'b1;
      else if (stuck && $urandom_range(0, 39) == 0) stuck = 1'b0;
      pready  = !stuck && ($urandom_range(0, 2) != 0);
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 3) == 0);
      model_step();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{2, 1'b1, 10'h01C, 32'hDEADBEEF, 0,   32'hA5A5A5A5, 1'b0, 3,  32'hA5A5A5A5, 1'b0};
    vecs[1] = '{0, 1'b0, 10'h3FF, 32'h00000000, 3,   32'h12345678, 1'b1, 6,  32'h12345678, 1'b1};
    vecs[2] = '{1, 1'b0, 10'h155, 32'h00000000, 255, 32'h00000000, 1'b0, 18, 32'h00000000, 1'b1};
    vecs[3] = '{3, 1'b1, 10'h2AA, 32'h0F0F0F0F, 15,  32'h11111111, 1'b0, 18, 32'h11111111, 1'b0};
    vecs[4] = '{2, 1'b0, 10'h000, 32'h00000000, 1,   32'hCAFEF00D, 1'b0, 4,  32'hCAFEF00D, 1'b0};

    resetn = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("reset_state", {gnt, done, rsp_rdata, rsp_err, busy, psel, penable, pwrite, paddr, pwdata}, '0);
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    seq_fairness();
    seq_timeout();
    seq_reset_mid();
    seq_mask();
    seq_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
